// File: rtl/alu_rr_arbiter_if.sv
// alu_rr_arbiter_if: request, ALU and response signals of the shared-ALU round-robin arbiter
interface alu_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_op;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_zero;
    logic                      alu_overflow;
    logic                      alu_carry;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic [2:0]                rsp_flags;
    logic                      rsp_err;
    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, alu_overflow, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero, alu_overflow, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one 32-bit ALU between NUM_REQ requesters
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input logic clk,
    input logic rst,
    alu_rr_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t              r_state, w_next;
    logic [ID_W-1:0]     r_ptr, r_id, w_grant, w_idx;
    logic                w_any, w_accept;
    logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_rsp_result;
    logic [OP_W-1:0]     r_alu_op;
    logic                r_rsp_valid, r_rsp_err;
    logic [ID_W-1:0]     r_rsp_id;
    logic [2:0]          r_rsp_flags;
    // Descending scan so the lowest offset from r_ptr wins
    always_comb begin
        w_grant = r_ptr;
        w_idx = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            w_grant = bus.req_valid[w_idx] ? w_idx : w_grant;
        end
    end
    assign w_any    = |bus.req_valid;
    assign w_accept = !rst && w_any && (r_state == IDLE || (r_state == RESP && bus.rsp_ready));
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? EXEC :
                 (r_state == EXEC) ? RESP :
                 (r_state == RESP && bus.rsp_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_id         <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_ptr    <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
                r_id     <= w_grant;
                r_alu_a  <= bus.req_a[w_grant*DATA_W +: DATA_W];
                r_alu_b  <= bus.req_b[w_grant*DATA_W +: DATA_W];
                r_alu_op <= bus.req_op[w_grant*OP_W +: OP_W];
            end
            if (r_state == EXEC) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_result <= bus.alu_result;
                r_rsp_flags  <= {bus.alu_carry, bus.alu_overflow, bus.alu_zero};
                r_rsp_err    <= r_alu_op > OP_W'(9);
            end else if (r_state == RESP && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end
    assign bus.req_ready  = w_accept ? NUM_REQ'(1) << w_grant : '0;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_err    = r_rsp_err;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed self-checking bench with a behavioural ALU stand-in
module tb_alu_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [32:0] t;
    alu_rr_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .OP_W(4)) bus ();
    alu_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .OP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // ADD/SUB with carry (borrow for SUB) and signed overflow; anything else yields 0
    always_comb begin
        t = 33'd0;
        bus.alu_overflow = 1'b0;
        if (bus.alu_op == 4'd0) begin
            t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (t[31] != bus.alu_a[31]);
        end else if (bus.alu_op == 4'd1) begin
            t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (t[31] != bus.alu_a[31]);
        end
        bus.alu_result = t[31:0];
        bus.alu_carry  = t[32];
        bus.alu_zero   = t[31:0] == 32'd0;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_op[i*4 +: 4]  = op;
    endtask
    task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] er, input logic [2:0] ef, input logic ee);
        bus.req_valid = 4'b0001 << i;
        set_req(i, a, b, op);
        #1 chk("op_ready", 64'(bus.req_ready), 64'(4'b0001 << i));
        @(negedge clk);
        bus.req_valid = '0;
        chk("op_exec_valid", 64'(bus.rsp_valid), 64'd0);
        chk("op_alu_a", 64'(bus.alu_a), 64'(a));
        chk("op_alu_op", 64'(bus.alu_op), 64'(op));
        @(negedge clk);
        chk("op_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("op_rsp_id", 64'(bus.rsp_id), 64'(i));
        chk("op_rsp_result", 64'(bus.rsp_result), 64'(er));
        chk("op_rsp_flags", 64'(bus.rsp_flags), 64'(ef));
        chk("op_rsp_err", 64'(bus.rsp_err), 64'(ee));
        @(negedge clk);
        chk("op_idle_valid", 64'(bus.rsp_valid), 64'd0);
        chk("op_alu_a_hold", 64'(bus.alu_a), 64'(a));
    endtask
    initial begin
        bus.req_valid = 4'b0001;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd3, 4'd0);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
        chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        rst = 1'b0;
        run_op(0, 32'd5, 32'd3, 4'd0, 32'd8, 3'b000, 1'b0);
        // All four requesters valid from reset: grants 0,1,2,3,0 two cycles apart
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 32'(10 * (i + 1)), 32'(i), 4'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << (k % 4)));
            @(negedge clk);
            chk("rr_exec_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
            chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rr_rsp_id", 64'(bus.rsp_id), 64'(k % 4));
            chk("rr_rsp_result", 64'(bus.rsp_result), 64'(10 * ((k % 4) + 1) + (k % 4)));
        end
        bus.req_valid = '0;
        @(negedge clk);
        // Backpressure: ptr is 1, only req0 valid -> grant 0; req1 waits behind the stalled response
        bus.req_valid = 4'b0001;
        set_req(0, 32'd7, 32'd2, 4'd1);
        bus.rsp_ready = 1'b0;
        #1 chk("bp_ready0", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = 4'b0010;
        set_req(1, 32'd100, 32'd23, 4'd0);
        #1 chk("bp_exec_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_result", 64'(bus.rsp_result), 64'd5);
            chk("bp_rsp_id", 64'(bus.rsp_id), 64'd0);
            chk("bp_stall_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp_ready1", 64'(bus.req_ready), 64'b0010);
        @(negedge clk);
        bus.req_valid = '0;
        chk("bp_exec_valid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("bp_rsp1_id", 64'(bus.rsp_id), 64'd1);
        chk("bp_rsp1_result", 64'(bus.rsp_result), 64'd123);
        @(negedge clk);
        // Flags and illegal opcode
        run_op(2, 32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 3'b010, 1'b0);
        run_op(3, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 3'b101, 1'b0);
        run_op(0, 32'd5, 32'd6, 4'hF, 32'd0, 3'b001, 1'b1);
        // Reset during EXEC drops the operation and restarts arbitration at requester 0
        bus.req_valid = 4'b0100;
        set_req(2, 32'd9, 32'd9, 4'd0);
        #1 chk("rx_ready", 64'(bus.req_ready), 64'b0100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rx_alu_a", 64'(bus.alu_a), 64'd0);
        chk("rx_alu_op", 64'(bus.alu_op), 64'd0);
        chk("rx_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rx_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_no_rsp0", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        chk("rx_no_rsp1", 64'(bus.rsp_valid), 64'd0);
        bus.req_valid = 4'b1001;
        set_req(0, 32'd1, 32'd2, 4'd0);
        set_req(3, 32'd4, 32'd4, 4'd0);
        #1 chk("rx_grant0", 64'(bus.req_ready), 64'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        chk("rx_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rx_rsp_result", 64'(bus.rsp_result), 64'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
